// File: rtl/axis_mm_tile_bridge.sv
// AXI-Stream to matrix-multiply core BRAM bridge: loads one weight tile and one input tile,
// pulses core_start, waits for core_ready, then streams results through a 2-entry output FIFO.
// Optional feature: define AXIS_MM_TLAST_CHECK_EN for a sticky slave-tlast framing error on err.
module axis_mm_tile_bridge #(
  parameter int WIDTH      = 16,
  parameter int CHUNK_SIZE = 4,
  parameter int NUM_CORES  = 2,
  parameter int W_WORDS    = 5,
  parameter int I_WORDS    = 2,
  parameter int O_WORDS    = 2,
  parameter int ADDR_W     = 4,
  localparam int WW = WIDTH * CHUNK_SIZE,
  localparam int IW = WW * NUM_CORES
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [WW-1:0]     s_axis_w_tdata,
  input  logic              s_axis_w_tvalid,
  output logic              s_axis_w_tready,
  input  logic              s_axis_w_tlast,
  input  logic [IW-1:0]     s_axis_i_tdata,
  input  logic              s_axis_i_tvalid,
  output logic              s_axis_i_tready,
  input  logic              s_axis_i_tlast,
  output logic [IW-1:0]     m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [WW-1:0]     wb_din,
  output logic              k_en,
  output logic [ADDR_W-1:0] k_addr,
  output logic [IW-1:0]     k_din,
  output logic              core_start,
  input  logic              core_ready,
  output logic              a_en,
  output logic [ADDR_W-1:0] a_addr,
  input  logic [IW-1:0]     a_dout,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W-1:0] W_LAST = ADDR_W'(W_WORDS - 1);
  localparam logic [ADDR_W-1:0] I_LAST = ADDR_W'(I_WORDS - 1);
  localparam logic [ADDR_W-1:0] O_LAST = ADDR_W'(O_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD_W, ST_LOAD_I, ST_START, ST_WAIT, ST_READ, ST_DRAIN
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg;

  logic w_hs, i_hs, rd_issue;
  logic rd_valid_reg, rd_last_reg;

  // Output FIFO storage; the entry arriving from the BRAM can bypass an empty FIFO.
  logic [IW-1:0] fifo_data [2];
  logic          fifo_last [2];
  logic          wr_ptr_reg, rd_ptr_reg;
  logic [1:0]    fifo_cnt_reg, fifo_cnt_next;
  logic          fifo_empty, out_valid, out_last, push, pop_fifo;
  logic [IW-1:0] out_data;

  assign w_hs = (state_reg == ST_LOAD_W) && s_axis_w_tvalid;
  assign i_hs = (state_reg == ST_LOAD_I) && s_axis_i_tvalid;

  // Reads are throttled so stored beats plus beats in flight never exceed the FIFO depth.
  assign rd_issue = (state_reg == ST_READ) &&
                    (({1'b0, fifo_cnt_reg} + {2'b00, rd_valid_reg}) < 3'd2);

  assign fifo_empty    = (fifo_cnt_reg == 2'd0);
  assign out_valid     = !fifo_empty || rd_valid_reg;
  assign out_data      = fifo_empty ? a_dout : fifo_data[rd_ptr_reg];
  assign out_last      = fifo_empty ? rd_last_reg : fifo_last[rd_ptr_reg];
  assign push          = rd_valid_reg && !(fifo_empty && m_axis_tready);
  assign pop_fifo      = !fifo_empty && m_axis_tready;
  assign fifo_cnt_next = fifo_cnt_reg + {1'b0, push} - {1'b0, pop_fifo};

  // State register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   state_next = ST_LOAD_W;
      ST_LOAD_W: if (w_hs && cnt_reg == W_LAST) state_next = ST_LOAD_I;
      ST_LOAD_I: if (i_hs && cnt_reg == I_LAST) state_next = ST_START;
      ST_START:  state_next = ST_WAIT;
      ST_WAIT:   if (core_ready) state_next = ST_READ;
      ST_READ:   if (rd_issue && cnt_reg == O_LAST) state_next = ST_DRAIN;
      ST_DRAIN:  if (fifo_cnt_next == 2'd0) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output logic; address/data buses are zero outside their strobes
  always_comb begin
    busy            = (state_reg != ST_IDLE);
    s_axis_w_tready = (state_reg == ST_LOAD_W);
    s_axis_i_tready = (state_reg == ST_LOAD_I);
    wb_en           = w_hs;
    wb_addr         = w_hs ? cnt_reg : '0;
    wb_din          = w_hs ? s_axis_w_tdata : '0;
    k_en            = i_hs;
    k_addr          = i_hs ? cnt_reg : '0;
    k_din           = i_hs ? s_axis_i_tdata : '0;
    core_start      = (state_reg == ST_START);
    a_en            = rd_issue;
    a_addr          = rd_issue ? cnt_reg : '0;
    m_axis_tvalid   = out_valid;
    m_axis_tdata    = out_valid ? out_data : '0;
    m_axis_tlast    = out_valid && out_last;
  end

  // Shared beat/read counter, cleared whenever the state changes
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt_reg <= '0;
    end else if (state_next != state_reg) begin
      cnt_reg <= '0;
    end else if (w_hs || i_hs || rd_issue) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_valid_reg <= 1'b0;
      rd_last_reg  <= 1'b0;
    end else begin
      rd_valid_reg <= rd_issue;
      rd_last_reg  <= rd_issue && (cnt_reg == O_LAST);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      fifo_cnt_reg <= 2'd0;
    end else begin
      if (push)     wr_ptr_reg <= ~wr_ptr_reg;
      if (pop_fifo) rd_ptr_reg <= ~rd_ptr_reg;
      fifo_cnt_reg <= fifo_cnt_next;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      fifo_data[wr_ptr_reg] <= a_dout;
      fifo_last[wr_ptr_reg] <= rd_last_reg;
    end
  end

`ifdef AXIS_MM_TLAST_CHECK_EN
  logic err_reg;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err_reg <= 1'b0;
    end else if ((w_hs && (s_axis_w_tlast != (cnt_reg == W_LAST))) ||
                 (i_hs && (s_axis_i_tlast != (cnt_reg == I_LAST)))) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_w_tlast ^ s_axis_i_tlast;
  assign err          = 1'b0;
`endif

endmodule
